ble_button_parser: RTL and testbench



---
 rtl/ble_button_parser.sv | 182 ++++++++++++++++++
 tb/tb_ble_button_parser.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ble_button_parser.sv
// Bluefruit button-packet parser: turns '!','B',id,action,checksum byte streams
// into single-cycle button events, a held-button bitmap and a saturating error count.
module ble_button_parser #(
  parameter int TIMEOUT_CYCLES = 742500,
  parameter int ERR_WIDTH      = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [7:0]           data_in,
  input  logic                 valid_in,
  output logic                 btn_valid_out,
  output logic [3:0]           btn_id_out,
  output logic                 btn_pressed_out,
  output logic [7:0]           btn_state_out,
  output logic [ERR_WIDTH-1:0] err_count_out,
  output logic                 busy_out
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [ERR_WIDTH-1:0] ERR_MAX = {ERR_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TYPE = 3'd1,
    S_ID   = 3'd2,
    S_ACT  = 3'd3,
    S_CSUM = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             sum_q, sum_d;
  logic [3:0]             id_q, id_d;
  logic                   act_q, act_d;
  logic [CW-1:0]          tmo_q, tmo_d;
  logic                   btn_valid_q, btn_valid_d;
  logic [3:0]             btn_id_q, btn_id_d;
  logic                   btn_pressed_q, btn_pressed_d;
  logic [7:0]             btn_state_q, btn_state_d;
  logic [ERR_WIDTH-1:0]   err_q, err_d;
  logic                   busy_q, busy_d;
  logic                   err_hit_s;
  logic                   is_bang_s;
  logic [2:0]             bit_idx_s;

  // Next-state, datapath and output computation
  always_comb begin
    state_d       = state_q;
    sum_d         = sum_q;
    id_d          = id_q;
    act_d         = act_q;
    tmo_d         = tmo_q;
    btn_valid_d   = 1'b0;
    btn_id_d      = btn_id_q;
    btn_pressed_d = btn_pressed_q;
    btn_state_d   = btn_state_q;
    err_d         = err_q;
    err_hit_s     = 1'b0;
    is_bang_s     = (data_in == 8'h21);
    bit_idx_s     = id_q[2:0] - 3'd1;

    if (valid_in) begin
      tmo_d = {CW{1'b0}};
      case (state_q)
        S_IDLE: begin
          if (is_bang_s) begin
            state_d = S_TYPE;
            sum_d   = 8'h21;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_TYPE: begin
          if (data_in == 8'h42) begin
            state_d = S_ID;
            sum_d   = sum_q + data_in;
          end else if (is_bang_s) begin
            state_d = S_TYPE;
            sum_d   = 8'h21;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ID: begin
          if (data_in >= 8'h31 && data_in <= 8'h38) begin
            state_d = S_ACT;
            sum_d   = sum_q + data_in;
            id_d    = data_in[3:0];
          end else begin
            err_hit_s = 1'b1;
          end
        end
        S_ACT: begin
          if (data_in == 8'h30 || data_in == 8'h31) begin
            state_d = S_CSUM;
            sum_d   = sum_q + data_in;
            act_d   = data_in[0];
          end else begin
            err_hit_s = 1'b1;
          end
        end
        S_CSUM: begin
          if (data_in == ~sum_q) begin
            state_d                = S_IDLE;
            btn_valid_d            = 1'b1;
            btn_id_d               = id_q;
            btn_pressed_d          = act_q;
            btn_state_d[bit_idx_s] = act_q;
          end else begin
            err_hit_s = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
      // A '!' that breaks a packet also opens the next one
      if (err_hit_s) begin
        if (is_bang_s) begin
          state_d = S_TYPE;
          sum_d   = 8'h21;
        end else begin
          state_d = S_IDLE;
        end
      end else begin
        err_hit_s = 1'b0;
      end
    end else if (state_q == S_IDLE) begin
      tmo_d = {CW{1'b0}};
    end else if (tmo_q == TMO_LAST) begin
      tmo_d     = {CW{1'b0}};
      state_d   = S_IDLE;
      err_hit_s = 1'b1;
    end else begin
      tmo_d = tmo_q + CW'(1);
    end

    if (err_hit_s && err_q != ERR_MAX) begin
      err_d = err_q + ERR_WIDTH'(1);
    end else begin
      err_d = err_q;
    end
    busy_d = (state_d != S_IDLE);
  end

  // Parser state and registered outputs
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= S_IDLE;
      sum_q         <= 8'h00;
      id_q          <= 4'h0;
      act_q         <= 1'b0;
      tmo_q         <= {CW{1'b0}};
      btn_valid_q   <= 1'b0;
      btn_id_q      <= 4'h0;
      btn_pressed_q <= 1'b0;
      btn_state_q   <= 8'h00;
      err_q         <= {ERR_WIDTH{1'b0}};
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      sum_q         <= sum_d;
      id_q          <= id_d;
      act_q         <= act_d;
      tmo_q         <= tmo_d;
      btn_valid_q   <= btn_valid_d;
      btn_id_q      <= btn_id_d;
      btn_pressed_q <= btn_pressed_d;
      btn_state_q   <= btn_state_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
    end
  end

  assign btn_valid_out   = btn_valid_q;
  assign btn_id_out      = btn_id_q;
  assign btn_pressed_out = btn_pressed_q;
  assign btn_state_out   = btn_state_q;
  assign err_count_out   = err_q;
  assign busy_out        = busy_q;

endmodule

// File: tb/tb_ble_button_parser.sv
// Randomised and directed bench for ble_button_parser against a packet-level
// reference model that keeps the bytes of the current packet in a queue.
module tb_ble_button_parser;

  localparam int T = 100;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       btn_valid_out;
  logic [3:0] btn_id_out;
  logic       btn_pressed_out;
  logic [7:0] btn_state_out;
  logic [7:0] err_count_out;
  logic       busy_out;

  int checks = 0;
  int errors = 0;

  ble_button_parser #(.TIMEOUT_CYCLES(T), .ERR_WIDTH(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .data_in(data_in), .valid_in(valid_in),
    .btn_valid_out(btn_valid_out), .btn_id_out(btn_id_out),
    .btn_pressed_out(btn_pressed_out), .btn_state_out(btn_state_out),
    .err_count_out(err_count_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference model state
  logic [7:0] pkt[$];
  int         cyc = 0;
  int         last_t = 0;
  logic       exp_valid = 1'b0;
  logic [3:0] exp_id = 4'h0;
  logic       exp_pressed = 1'b0;
  logic [7:0] exp_state = 8'h00;
  logic [7:0] exp_err = 8'h00;
  logic       exp_busy = 1'b0;

  function automatic logic [22:0] got_vec();
    return {btn_valid_out, btn_id_out, btn_pressed_out, btn_state_out, err_count_out, busy_out};
  endfunction

  function automatic logic [22:0] exp_vec();
    return {exp_valid, exp_id, exp_pressed, exp_state, exp_err, exp_busy};
  endfunction

  function automatic logic [7:0] csum(input int id, input int act);
    int s;
    s = 8'h21 + 8'h42 + 8'h30 + id + 8'h30 + act;
    return 8'(255 - (s % 256));
  endfunction

  task automatic model_err();
    if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
  endtask

  task automatic model_edge(input logic v, input logic [7:0] b);
    int n;
    int s;
    cyc++;
    exp_valid = 1'b0;
    n = pkt.size();
    if (v) begin
      if (n == 0) begin
        if (b == 8'h21) begin pkt = {b}; last_t = cyc; end
      end else if (n == 1) begin
        if (b == 8'h42) begin pkt.push_back(b); last_t = cyc; end
        else if (b == 8'h21) begin pkt = {b}; last_t = cyc; end
        else pkt.delete();
      end else if (n == 2 && b >= 8'h31 && b <= 8'h38) begin
        pkt.push_back(b); last_t = cyc;
      end else if (n == 3 && (b == 8'h30 || b == 8'h31)) begin
        pkt.push_back(b); last_t = cyc;
      end else begin
        s = b;
        foreach (pkt[i]) s += pkt[i];
        if (n == 4 && (s % 256) == 255) begin
          exp_valid   = 1'b1;
          exp_id      = 4'(pkt[2] - 8'h30);
          exp_pressed = pkt[3][0];
          exp_state[exp_id - 1] = exp_pressed;
          pkt.delete();
        end else begin
          model_err();
          if (b == 8'h21) begin pkt = {b}; last_t = cyc; end
          else pkt.delete();
        end
      end
    end else if (n != 0 && cyc - last_t == T) begin
      model_err();
      pkt.delete();
    end
    exp_busy = (pkt.size() != 0);
  endtask

  task automatic step(input logic v, input logic [7:0] b);
    @(negedge clk_in);
    valid_in = v;
    data_in  = b;
    @(posedge clk_in);
    model_edge(v, b);
    #1;
  endtask

  task automatic model_reset();
    pkt.delete();
    exp_valid = 1'b0; exp_id = 4'h0; exp_pressed = 1'b0;
    exp_state = 8'h00; exp_err = 8'h00; exp_busy = 1'b0;
  endtask

  task automatic send_checked(input logic [7:0] b, input string name);
    step(1'b1, b);
    checks++;
    if (got_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got_vec(), exp_vec());
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    model_reset();
    repeat (3) @(negedge clk_in);
    checks++;
    if (got_vec() !== 23'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", got_vec());
    end
    rst_in = 1'b0;
    step(1'b0, 8'h00);
    checks++;
    if (got_vec() !== 23'h0) begin
      errors++; $display("FAIL reset_idle: got %h expected 0", got_vec());
    end
  endtask

  task automatic test_press_release();
    logic [7:0] p[5];
    logic [7:0] r[5];
    p = '{8'h21, 8'h42, 8'h35, 8'h31, 8'h36};
    r = '{8'h21, 8'h42, 8'h35, 8'h30, 8'h37};
    foreach (p[i]) send_checked(p[i], "press_seq");
    checks++;
    if ({btn_valid_out, btn_id_out, btn_pressed_out, btn_state_out, err_count_out} !== {1'b1, 4'd5, 1'b1, 8'h10, 8'h00}) begin
      errors++; $display("FAIL press_5: got v=%b id=%0d p=%b st=%h err=%0d expected 1 5 1 10 0",
        btn_valid_out, btn_id_out, btn_pressed_out, btn_state_out, err_count_out);
    end
    step(1'b0, 8'h00);
    checks++;
    if (btn_valid_out !== 1'b0) begin
      errors++; $display("FAIL pulse_width: got %b expected 0", btn_valid_out);
    end
    foreach (r[i]) send_checked(r[i], "release_seq");
    checks++;
    if ({btn_valid_out, btn_pressed_out, btn_state_out} !== {1'b1, 1'b0, 8'h00}) begin
      errors++; $display("FAIL release_5: got v=%b p=%b st=%h expected 1 0 00",
        btn_valid_out, btn_pressed_out, btn_state_out);
    end
  endtask

  task automatic test_bad_csum();
    logic [7:0] q[5];
    q = '{8'h21, 8'h42, 8'h35, 8'h31, 8'h00};
    foreach (q[i]) send_checked(q[i], "badcsum_seq");
    checks++;
    if ({btn_valid_out, err_count_out, btn_state_out} !== {1'b0, 8'd1, 8'h00}) begin
      errors++; $display("FAIL bad_csum: got v=%b err=%0d st=%h expected 0 1 00",
        btn_valid_out, err_count_out, btn_state_out);
    end
  endtask

  task automatic test_timeout();
    int fell;
    fell = 0;
    send_checked(8'h21, "tmo_bang");
    send_checked(8'h42, "tmo_type");
    for (int i = 1; i <= T + 20; i++) begin
      step(1'b0, 8'h00);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL tmo_cycle%0d: got %h expected %h", i, got_vec(), exp_vec());
      end
      if (fell == 0 && busy_out == 1'b0) fell = i;
    end
    checks++;
    if (fell != T || err_count_out !== 8'd1) begin
      errors++; $display("FAIL timeout: got fell=%0d err=%0d expected %0d 1", fell, err_count_out, T);
    end
    send_checked(8'h21, "b2_seq");
    send_checked(8'h42, "b2_seq");
    send_checked(8'h32, "b2_seq");
    send_checked(8'h31, "b2_seq");
    send_checked(csum(2, 1), "b2_seq");
    checks++;
    if (btn_state_out !== 8'h02) begin
      errors++; $display("FAIL button2: got %h expected 02", btn_state_out);
    end
  endtask

  task automatic test_resync();
    logic [7:0] q[7];
    logic [7:0] c[5];
    logic [7:0] e0;
    e0 = err_count_out;
    q = '{8'h21, 8'h42, 8'h21, 8'h42, 8'h38, 8'h31, 8'h33};
    foreach (q[i]) send_checked(q[i], "resync_seq");
    checks++;
    if ({btn_valid_out, btn_id_out, btn_state_out[7], err_count_out} !== {1'b1, 4'd8, 1'b1, 8'(e0 + 8'd1)}) begin
      errors++; $display("FAIL resync_b8: got v=%b id=%0d st=%h err=%0d expected 1 8 bit7 %0d",
        btn_valid_out, btn_id_out, btn_state_out, err_count_out, e0 + 1);
    end
    e0 = err_count_out;
    c = '{8'h21, 8'h43, 8'h12, 8'h34, 8'h56};
    foreach (c[i]) send_checked(c[i], "color_seq");
    step(1'b0, 8'h00);
    checks++;
    if ({btn_valid_out, busy_out, err_count_out} !== {1'b0, 1'b0, e0}) begin
      errors++; $display("FAIL color_pkt: got v=%b busy=%b err=%0d expected 0 0 %0d",
        btn_valid_out, busy_out, err_count_out, e0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b[$];
    int kind;
    int id;
    int act;
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 9);
      id   = $urandom_range(1, 8);
      act  = $urandom_range(0, 1);
      b = {8'h21, 8'h42, 8'(8'h30 + id), 8'(8'h30 + act), csum(id, act)};
      case (kind)
        5: b[4] = b[4] ^ 8'(1 << $urandom_range(0, 7));
        6: b[2] = 8'($urandom_range(0, 255));
        7: b[3] = 8'($urandom_range(0, 255));
        8: b[1] = 8'($urandom_range(0, 255));
        9: b[$urandom_range(2, 4)] = 8'h21;
        default: ;
      endcase
      foreach (b[i]) begin
        send_checked(b[i], "rand_pkt");
        if ((n % 37) == 5 && i == 2) begin
          repeat (T + 2) begin
            step(1'b0, 8'h00);
            checks++;
            if (got_vec() !== exp_vec()) begin
              errors++; $display("FAIL rand_tmo: got %h expected %h", got_vec(), exp_vec());
            end
          end
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        step(1'b0, 8'h00);
        checks++;
        if (got_vec() !== exp_vec()) begin
          errors++; $display("FAIL rand_gap: got %h expected %h", got_vec(), exp_vec());
        end
      end
    end
  endtask

  task automatic test_saturate_and_async_reset();
    for (int n = 0; n < 300; n++) begin
      send_checked(8'h21, "sat_seq");
      send_checked(8'h42, "sat_seq");
      send_checked(8'h33, "sat_seq");
      send_checked(8'h31, "sat_seq");
      send_checked(8'(csum(3, 1) ^ 8'h01), "sat_seq");
    end
    checks++;
    if (err_count_out !== 8'd255) begin
      errors++; $display("FAIL saturate: got %0d expected 255", err_count_out);
    end
    send_checked(8'h21, "pre_rst");
    send_checked(8'h42, "pre_rst");
    send_checked(8'h34, "pre_rst");
    send_checked(8'h31, "pre_rst");
    send_checked(csum(4, 1), "pre_rst");
    send_checked(8'h21, "mid_pkt");
    send_checked(8'h42, "mid_pkt");
    @(negedge clk_in);
    valid_in = 1'b0;
    #2 rst_in = 1'b1;
    model_reset();
    #1;
    checks++;
    if (got_vec() !== 23'h0) begin
      errors++; $display("FAIL async_reset: got %h expected 0", got_vec());
    end
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_bad_csum();
    test_reset();
    test_timeout();
    test_resync();
    test_back_to_back();
    test_saturate_and_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
